// File: rtl/determinant_reciprocal.sv
// Reciprocal of an IEEE-754 single-precision determinant via 26-step restoring division.
// Define RECIP_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module determinant_reciprocal (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] det,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] recip,
  output logic        singular
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] det_reg;
  logic [24:0] rem;
  logic [25:0] quo;
  logic [4:0]  cnt;
  logic        valid_reg;
  logic [31:0] recip_reg;
  logic        singular_reg;
  logic        accept;

  logic        sign;
  logic [7:0]  exp_in;
  logic [22:0] man_in;
  logic [24:0] divisor;
  logic [24:0] diff;
  logic        q_bit;
  logic [24:0] rem_next;
  logic [9:0]  exp_calc;
  logic        flush;
  logic [22:0] mant_sel;
  logic        round_up;
  logic [23:0] mant_sum;
  logic [31:0] norm_recip;
  logic        norm_singular;

  assign accept  = in_valid && in_ready;
  assign sign    = det_reg[31];
  assign exp_in  = det_reg[30:23];
  assign man_in  = det_reg[22:0];

  // Remainder is kept pre-shifted; starting at 2.0 puts the leading quotient bit at 2^0.
  assign divisor  = {2'b01, man_in};
  assign q_bit    = (rem >= divisor);
  assign diff     = rem - divisor;
  assign rem_next = q_bit ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = DIV;
      DIV:  if (cnt == 5'd25) state_next = NORM;
      NORM: state_next = DONE;
      DONE: if (valid_reg && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = valid_reg;
    recip     = recip_reg;
    singular  = singular_reg;
  end

  // The leading quotient bit is always set for m != 0; the select keeps normalisation explicit.
  assign mant_sel = quo[25] ? quo[24:2] : quo[23:1];

`ifdef RECIP_ROUND_EN
  logic guard;
  logic sticky;
  assign guard    = quo[25] ? quo[1] : quo[0];
  assign sticky   = (quo[25] & quo[0]) | (|rem);
  assign round_up = guard & (sticky | mant_sel[0]);
`else
  assign round_up = 1'b0;
`endif

  assign mant_sum = {1'b0, mant_sel} + {23'd0, round_up};
  assign exp_calc = ((man_in == 23'd0) ? 10'd254 : 10'd253) - {2'b00, exp_in};
  assign flush    = exp_calc[9] || (exp_calc == 10'd0);

  always_comb begin
    norm_recip    = 32'h0000_0000;
    norm_singular = 1'b0;
    if (exp_in == 8'h00) begin
      norm_recip    = {sign, 8'hFF, 23'd0};
      norm_singular = 1'b1;
    end else if (exp_in == 8'hFF) begin
      norm_recip = (man_in == 23'd0) ? {sign, 31'd0} : 32'h7FC0_0000;
    end else if (flush) begin
      norm_recip = {sign, 31'd0};
    end else if (man_in == 23'd0) begin
      norm_recip = {sign, exp_calc[7:0], 23'd0};
    end else if (mant_sum[23]) begin
      norm_recip = {sign, exp_calc[7:0] + 8'd1, 23'd0};
    end else begin
      norm_recip = {sign, exp_calc[7:0], mant_sum[22:0]};
    end
  end

  // out_valid rises one cycle into DONE, giving the fixed 28-edge latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      det_reg      <= 32'd0;
      rem          <= 25'd0;
      quo          <= 26'd0;
      cnt          <= 5'd0;
      valid_reg    <= 1'b0;
      recip_reg    <= 32'd0;
      singular_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            det_reg <= det;
            rem     <= 25'h100_0000;
            quo     <= 26'd0;
            cnt     <= 5'd0;
          end
        end
        DIV: begin
          rem <= rem_next;
          quo <= {quo[24:0], q_bit};
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          recip_reg    <= norm_recip;
          singular_reg <= norm_singular;
        end
        DONE: begin
          if (!valid_reg) begin
            valid_reg <= 1'b1;
          end else if (out_ready) begin
            valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_determinant_reciprocal.sv
// Self-checking bench for determinant_reciprocal: directed spec cases plus randomized
// operands scored against an integer-arithmetic reciprocal model.
module tb_determinant_reciprocal;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] det = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] recip;
  logic        singular;

  int check_count = 0;
  int fail_count  = 0;

  always #5 clk = ~clk;

  determinant_reciprocal dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .det       (det),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .recip     (recip),
    .singular  (singular)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reciprocal significand from one wide integer division, then normalised and rounded.
  function automatic logic [32:0] ref_model(input logic [31:0] d);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [63:0] num;
    logic [63:0] den;
    logic [63:0] q;
    logic [63:0] r;
    logic [23:0] sig;
    int          lead;
    int          shift;
    int          biased;
    s = d[31];
    e = d[30:23];
    m = d[22:0];
    if (e == 8'd0) return {1'b1, s, 8'hFF, 23'd0};
    if (e == 8'hFF) return (m == 23'd0) ? {1'b0, s, 31'd0} : {1'b0, 32'h7FC0_0000};
    num = 64'd1 << 62;
    den = {40'd0, 1'b1, m};
    q = num / den;
    r = num % den;
    lead = q[39] ? 39 : 38;
    biased = 254 - int'(e) + (lead - 39);
    if (biased <= 0) return {1'b0, s, 31'd0};
    shift = lead - 23;
    sig = 24'(q >> shift);
`ifdef RECIP_ROUND_EN
    begin
      logic guard;
      logic sticky;
      guard  = q[shift-1];
      sticky = ((q & ((64'd1 << (shift - 1)) - 64'd1)) != 64'd0) || (r != 64'd0);
      if (guard && (sticky || sig[0])) begin
        if (sig == 24'hFF_FFFF) begin
          sig = 24'h80_0000;
          biased++;
        end else begin
          sig = sig + 24'd1;
        end
      end
    end
`else
    if (r == 64'd0) sig = sig;
`endif
    return {1'b0, s, 8'(biased), sig[22:0]};
  endfunction

  task automatic applyStimulus(input logic [31:0] d, input int bp_cycles, input logic [31:0] exp_recip,
                               input logic exp_singular, input string tag);
    int          n;
    logic        bp_ok;
    logic [31:0] held;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_ready_before"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    det       = d;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    det      = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) checkOutput({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
    end
    checkOutput({tag, "_latency"}, n, 32'd28);
    checkOutput({tag, "_recip"}, recip, exp_recip);
    checkOutput({tag, "_singular"}, {31'd0, singular}, {31'd0, exp_singular});
    held  = recip;
    bp_ok = 1'b1;
    for (int i = 0; i < bp_cycles; i++) begin
      in_valid = 1'b1;
      det      = $urandom;
      @(posedge clk);
      #1;
      if (!(out_valid && !in_ready && recip === held)) bp_ok = 1'b0;
    end
    if (bp_cycles > 0) checkOutput({tag, "_bp_stable"}, {31'd0, bp_ok}, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_hs_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_hs_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [32:0] m_out;
    logic [31:0] d;
    logic [31:0] exp10;
    logic [31:0] expm6;
    logic [31:0] exp3;
    int          n;
`ifdef RECIP_ROUND_EN
    exp10 = 32'h3DCC_CCCD;
    expm6 = 32'hBE2A_AAAB;
    exp3  = 32'h3EAA_AAAB;
`else
    exp10 = 32'h3DCC_CCCC;
    expm6 = 32'hBE2A_AAAA;
    exp3  = 32'h3EAA_AAAA;
`endif

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_recip", recip, 32'd0);
    checkOutput("reset_singular", {31'd0, singular}, 32'd0);
    rst = 1'b1;

    applyStimulus(32'h4000_0000, 0, 32'h3F00_0000, 1'b0, "two");
    applyStimulus(32'h4120_0000, 0, exp10, 1'b0, "ten");
    applyStimulus(32'hC0C0_0000, 0, expm6, 1'b0, "neg_six");
    applyStimulus(32'h0000_0000, 0, 32'h7F80_0000, 1'b1, "pos_zero");
    applyStimulus(32'h8000_0000, 0, 32'hFF80_0000, 1'b1, "neg_zero");
    applyStimulus(32'h7FC0_0000, 0, 32'h7FC0_0000, 1'b0, "nan");
    applyStimulus(32'h7F80_0000, 0, 32'h0000_0000, 1'b0, "inf");
    applyStimulus(32'h7F00_0000, 0, 32'h0000_0000, 1'b0, "flush_e254");
    applyStimulus(32'h4040_0000, 10, exp3, 1'b0, "backpressure");

    // Abort during the tenth DIV cycle, then confirm the block recovers cleanly.
    @(negedge clk);
    in_valid = 1'b1;
    det      = 32'h4000_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    applyStimulus(32'h4080_0000, 0, 32'h3E80_0000, 1'b0, "after_reset");

    // Back-to-back with in_valid held high and the consumer always ready.
    @(negedge clk);
    in_valid  = 1'b1;
    det       = 32'h4120_0000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    det = 32'h4040_0000;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("b2b_first_latency", n, 32'd28);
    checkOutput("b2b_first_recip", recip, exp10);
    @(posedge clk);
    #1;
    checkOutput("b2b_idle_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("b2b_second_accepted", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("b2b_second_latency", n, 32'd28);
    checkOutput("b2b_second_recip", recip, exp3);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    for (int k = 0; k < 60; k++) begin
      d = $urandom;
      case ($urandom_range(0, 7))
        0: d[30:23] = 8'h00;
        1: d[30:23] = 8'hFF;
        2: d[30:23] = 8'(252 + $urandom_range(0, 2));
        3: d[22:0]  = 23'd0;
        4: d[22:0]  = 23'h7F_FFFF;
        default: ;
      endcase
      m_out = ref_model(d);
      applyStimulus(d, $urandom_range(0, 3), m_out[31:0], m_out[32], $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/determinant_reciprocal.md
DETERMINANT_RECIPROCAL -- requirements
Module: determinant_reciprocal

Interface
REQ-001 Parameters: none; the data width is fixed at 32 bits, IEEE-754 single precision.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  det is valid this cycle.
REQ-005 in_ready  output  1  block can accept det this cycle.
REQ-006 det  input  32  IEEE-754 single-precision determinant from the 2x2 determinant stage.
REQ-007 out_valid  output  1  recip and singular are valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 recip  output  32  IEEE-754 single-precision value of 1/det.
REQ-010 singular  output  1  det was zero or denormal.

Function
REQ-011 The FSM SHALL have four states with these transitions:
- IDLE -> DIV on accept.
- DIV -> NORM after 26 cycles.
- NORM -> DONE after 1 cycle.
- DONE -> IDLE on out_valid && out_ready.
REQ-012 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready; det SHALL be registered on accept, so det may change afterwards.
REQ-013 DIV SHALL compute one quotient bit per cycle, 26 bits in total, by restoring division of 1.0 by the 24-bit significand 1.m, and SHALL keep the final remainder as sticky.
REQ-014 Sign and exponent rules:
- sign(recip) = sign(det).
- m == 0: biased exponent = 254 - e, mantissa 0.
- m != 0: biased exponent = 253 - e, mantissa = normalised quotient bits.
REQ-015 NORM SHALL apply rounding (REQ-024) and produce the final recip/singular; if rounding carries the mantissa out, exponent +1 and mantissa = 0.
REQ-016 Special cases (all take full latency, no bypass):
- e == 0 (zero or denormal): recip = sign|0x7F800000, singular = 1.
- e == 255, m == 0 (infinity): recip = signed zero.
- NaN: recip = 0x7FC00000.
REQ-017 A computed biased exponent <= 0 SHALL flush recip to signed zero; singular = 0 in that case.
REQ-018 Latency: out_valid SHALL rise exactly 28 rising edges after the accept edge, for every input.
REQ-019 In DONE, recip, singular and out_valid SHALL hold stable until out_ready is 1; backpressure of any length SHALL lose no data.
REQ-020 Earliest next accept is the cycle after the DONE handshake, since IDLE is re-entered; at most one operation is in flight; in_valid outside IDLE is ignored.

Reset
REQ-021 When rst == 0 at a clock edge, the block SHALL enter IDLE with in_ready = 1, out_valid = 0, recip = 0x00000000, singular = 0, and the quotient, remainder and counter cleared.
REQ-022 Reset mid-DIV or in DONE SHALL abort the operation with no output handshake; the first valid accept after reset SHALL compute normally.
REQ-023 Reset has priority over accept and over the output handshake in the same cycle.

Configuration
REQ-024 Macro RECIP_ROUND_EN:
- Defined: NORM SHALL round to nearest-even using the guard bit plus (extra quotient bit OR remainder != 0).
- Undefined: NORM SHALL truncate (round toward zero).
- Latency, FSM and special-case handling are identical in both builds.

Verification
REQ-025 Handshake and reset values:
- rst = 0 for 2 cycles -> out_valid = 0, in_ready = 1, recip = 0.
- det = 0x40000000 (2.0) -> recip = 0x3F000000, singular = 0, out_valid on the 28th edge after accept.
REQ-026 Rounding:
- det = 0x41200000 (10.0) -> recip = 0x3DCCCCCD with RECIP_ROUND_EN, 0x3DCCCCCC without.
- det = 0xC0C00000 (-6.0) -> 0xBE2AAAAB with, 0xBE2AAAAA without.
REQ-027 Specials:
- det = 0x00000000 -> recip = 0x7F800000, singular = 1.
- det = 0x80000000 -> 0xFF800000, singular = 1.
- det = 0x7FC00000 -> 0x7FC00000.
- det = 0x7F800000 -> 0x00000000.
REQ-028 Backpressure: out_ready = 0 for 10 cycles after out_valid -> recip stable and in_ready = 0 throughout; det toggled meanwhile is not accepted; the handshake then returns to IDLE.
REQ-029 Mid-operation reset: rst = 0 on the 10th DIV cycle -> next edge shows IDLE with out_valid = 0; a new det = 0x40800000 (4.0) -> 0x3E800000.
REQ-030 Back-to-back: 0x41200000 then 0x40400000 (3.0), in_valid held high -> two results in order, 0x3DCCCCCD then 0x3EAAAAAB (rounded build), each with 28-cycle latency.
